// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - entry layout constants and packing helper for the button event queue
package button_pkg;

    localparam int ENTRY_W  = 32;
    localparam int TS_MSB   = 31;
    localparam int TS_LSB   = 16;
    localparam int MASK_MSB = 15;
    localparam int MASK_LSB = 0;
    localparam int TS_W     = TS_MSB - TS_LSB + 1;
    localparam int MASK_W   = MASK_MSB - MASK_LSB + 1;

    // Pack a timestamp and a (zero-extended) hit mask into one queue entry
    function automatic logic [ENTRY_W-1:0] make_entry(input logic [TS_W-1:0]   ts,
                                                      input logic [MASK_W-1:0] mask);
        logic [ENTRY_W-1:0] e;
        e                   = '0;
        e[TS_MSB:TS_LSB]     = ts;
        e[MASK_MSB:MASK_LSB] = mask;
        return e;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous show-ahead FIFO with clear and async active-low reset
module event_fifo
    import button_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    // Head is gated so stale memory never leaks out while empty
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop on empty is ignored; a push on full only lands if a pop frees a slot
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array needs no reset; writes are suppressed by clear
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; clear outranks push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - timestamped rising-edge event queue for button capture bits
module button_event_queue
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS = 8,
    parameter int DEPTH       = 16,
    parameter int PRESCALE    = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            capture,
    input  logic [NUM_BUTTONS-1:0] enable_mask,
    input  logic                   clear,
    input  logic                   rd_en,
    output logic [31:0]            rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [8:0]             count,
    output logic                   overflow,
    output logic                   irq
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [NUM_BUTTONS-1:0] prev_q;
    logic                   armed_q;
    logic [NUM_BUTTONS-1:0] hit;
    logic [MASK_W-1:0]      hit_ext;
    logic                   push;
    logic                   drop;
    logic [PS_W-1:0]        ps_q, ps_d;
    logic [TS_W-1:0]        ts_q, ts_d;
    logic                   overflow_q, overflow_d;
    logic                   irq_q;
    logic                   unused_capture;

    assign unused_capture = ^capture[31:NUM_BUTTONS];

    // armed_q blocks the first cycle after reset so a bit already high is not an edge
    assign hit  = armed_q ? (capture[NUM_BUTTONS-1:0] & ~prev_q & enable_mask) : '0;
    assign push = |hit;
    // Full implies non-empty, so only a missing rd_en makes the push fall on the floor
    assign drop = push && full && !rd_en;

    // Zero-extend the hit vector into the entry's mask field
    always_comb begin
        hit_ext                  = '0;
        hit_ext[NUM_BUTTONS-1:0] = hit;
    end

    // Edge-detect history; keeps tracking capture even through clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= capture[NUM_BUTTONS-1:0];
            armed_q <= 1'b1;
        end
    end

    // Next prescaler/timestamp: tick every PRESCALE cycles, 16-bit wrap is silent
    always_comb begin
        ps_d = ps_q + PS_W'(1);
        ts_d = ts_q;
        if (clear) begin
            ps_d = '0;
            ts_d = '0;
        end else if (ps_q == PS_W'(PRESCALE - 1)) begin
            ps_d = '0;
            ts_d = ts_q + TS_W'(1);
        end
    end

    // Prescaler and timestamp registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= '0;
            ts_q <= '0;
        end else begin
            ps_q <= ps_d;
            ts_q <= ts_d;
        end
    end

    // Sticky overflow: set on a dropped event, cleared only by clear
    always_comb begin
        overflow_d = overflow_q;
        if (clear) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow and interrupt registers; irq follows current status one cycle late
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            irq_q      <= !empty || overflow_q;
        end
    end

    assign overflow = overflow_q;
    assign irq      = irq_q;

    event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (9)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .push_i  (push),
        .data_i  (make_entry(ts_q, hit_ext)),
        .pop_i   (rd_en),
        .data_o  (rd_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_button_event_queue.sv
// tb/tb_button_event_queue.sv - self-checking bench for button_event_queue
module tb_button_event_queue;

    localparam int NB = 8;
    localparam int D  = 16;

    typedef struct {
        int         cyc;
        logic [7:0] mask;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] capture = '0;
    logic [7:0]  enable_mask = 8'hFF;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;

    logic [31:0] rd_data1, rd_data3;
    logic        empty1, empty3, full1, full3, ovf1, ovf3, irq1, irq3;
    logic [8:0]  count1, count3;

    int n_cmp = 0;
    int n_err = 0;

    ent_t       mq[$];
    logic [7:0] m_prev;
    logic       m_ovf, m_irq, m_armed;
    int         m_cyc;

    always #5 clk = ~clk;

    button_event_queue #(.NUM_BUTTONS(NB), .DEPTH(D), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .capture(capture), .enable_mask(enable_mask),
        .clear(clear), .rd_en(rd_en), .rd_data(rd_data1), .empty(empty1),
        .full(full1), .count(count1), .overflow(ovf1), .irq(irq1)
    );

    button_event_queue #(.NUM_BUTTONS(NB), .DEPTH(D), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst(rst), .capture(capture), .enable_mask(enable_mask),
        .clear(clear), .rd_en(rd_en), .rd_data(rd_data3), .empty(empty3),
        .full(full3), .count(count3), .overflow(ovf3), .irq(irq3)
    );

    function automatic logic [31:0] exp_head(input int p);
        if (mq.size() == 0) return 32'h0;
        return {16'(mq[0].cyc / p), 8'h00, mq[0].mask};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/count1"}, 32'(count1), 32'(mq.size()));
        chk({tag, "/count3"}, 32'(count3), 32'(mq.size()));
        chk({tag, "/empty1"}, 32'(empty1), 32'(mq.size() == 0));
        chk({tag, "/empty3"}, 32'(empty3), 32'(mq.size() == 0));
        chk({tag, "/full1"},  32'(full1),  32'(mq.size() == D));
        chk({tag, "/full3"},  32'(full3),  32'(mq.size() == D));
        chk({tag, "/ovf1"},   32'(ovf1),   32'(m_ovf));
        chk({tag, "/ovf3"},   32'(ovf3),   32'(m_ovf));
        chk({tag, "/irq1"},   32'(irq1),   32'(m_irq));
        chk({tag, "/irq3"},   32'(irq3),   32'(m_irq));
        chk({tag, "/data1"},  rd_data1,    exp_head(1));
        chk({tag, "/data3"},  rd_data3,    exp_head(3));
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev  = '0;
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        m_armed = 1'b0;
        m_cyc   = 0;
    endtask

    // Advance the reference model by one clock using the inputs now applied, then check
    task automatic step(input string tag);
        logic [7:0] hit;
        logic       irq_n;
        bit         popped;
        ent_t       e;
        if (rst) begin
            hit   = m_armed ? (capture[7:0] & ~m_prev & enable_mask) : 8'h00;
            irq_n = (mq.size() != 0) || m_ovf;
            if (clear) begin
                mq.delete();
                m_ovf = 1'b0;
                m_cyc = 0;
            end else begin
                popped = rd_en && (mq.size() != 0);
                if (hit != 0 && mq.size() == D && !popped) begin
                    m_ovf = 1'b1;
                end else begin
                    if (popped) mq.delete(0);
                    if (hit != 0) begin
                        e.cyc  = m_cyc;
                        e.mask = hit;
                        mq.push_back(e);
                    end
                end
                m_cyc++;
            end
            m_prev  = capture[7:0];
            m_irq   = irq_n;
            m_armed = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // First event: timestamp equals elapsed cycles with PRESCALE=1
        repeat (5) step("idle");
        capture = 32'h0000_0004;
        step("r36_push");
        chk("r36_data", rd_data1, 32'h0005_0004);
        chk("r36_count", 32'(count1), 32'd1);
        step("r36_irq");
        chk("r36_irq_hi", 32'(irq1), 32'd1);

        // Simultaneous rising edges merge into one entry
        rd_en = 1'b1;
        step("r37_drain");
        rd_en = 1'b0;
        capture = 32'h0000_000D;
        step("r37_push");
        chk("r37_mask", 32'(rd_data1[15:0]), 32'h0009);
        repeat (3) step("r37_hold");
        chk("r37_count", 32'(count1), 32'd1);

        // Disabled button produces nothing; pop on empty is harmless
        rd_en = 1'b1;
        step("r39_drain");
        enable_mask = 8'hFE;
        capture = 32'h0;
        step("r39_low");
        for (int i = 0; i < 4; i++) begin
            capture[0] = ~capture[0];
            step("r39_toggle");
        end
        chk("r39_count", 32'(count1), 32'd0);
        chk("r39_data", rd_data1, 32'h0);
        rd_en = 1'b0;

        // Fill to DEPTH, overflow, then simultaneous push and pop at full
        enable_mask = 8'hFF;
        for (int i = 0; i < D; i++) begin
            capture[4] = 1'b1;
            step("r38_fill_hi");
            capture[4] = 1'b0;
            step("r38_fill_lo");
        end
        chk("r38_full", 32'(full1), 32'd1);
        capture[4] = 1'b1;
        step("r38_over");
        chk("r38_cnt16", 32'(count1), 32'd16);
        chk("r38_ovf", 32'(ovf1), 32'd1);
        capture[4] = 1'b0;
        step("r38_lo");
        capture[4] = 1'b1;
        rd_en = 1'b1;
        step("r38_pushpop");
        rd_en = 1'b0;
        chk("r38_cnt_pp", 32'(count1), 32'd16);
        chk("r38_ovf_pp", 32'(ovf1), 32'd1);

        // Clear beats a coincident edge and restarts the timestamp
        rd_en = 1'b1;
        repeat (13) step("r40_drain");
        rd_en = 1'b0;
        chk("r40_pre_cnt", 32'(count1), 32'd3);
        clear = 1'b1;
        capture[5] = 1'b1;
        step("r40_clear");
        clear = 1'b0;
        chk("r40_cnt", 32'(count1), 32'd0);
        chk("r40_ovf", 32'(ovf1), 32'd0);
        capture[6] = 1'b1;
        step("r40_after");
        chk("r40_irq", 32'(irq1), 32'd0);
        chk("r40_ts", 32'(rd_data1[31:16]), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            capture     = capture ^ ($urandom & $urandom);
            enable_mask = 8'($urandom);
            rd_en       = 1'($urandom_range(0, 1));
            clear       = ($urandom_range(0, 39) == 0);
            step("rand");
        end
        clear = 1'b0;
        rd_en = 1'b0;

        // Asynchronous reset mid-stream with capture[1] held high
        enable_mask = 8'hFF;
        capture = 32'h0;
        step("r41_low");
        capture = 32'h0000_0002;
        step("r41_push");
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("r41_rst");
        chk("r41_rst_empty", 32'(empty1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step("r41_hold");
        chk("r41_noevt", 32'(count1), 32'd0);
        capture[1] = 1'b0;
        step("r41_fall");
        capture[1] = 1'b1;
        step("r41_rise");
        chk("r41_count", 32'(count1), 32'd1);
        chk("r41_mask", 32'(rd_data1[15:0]), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_event_queue.md
BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 8, the number of active capture bits (legal 1..16).
REQ-002 SHALL have parameter DEPTH, default 16, the queue entries (power of two, 2..256).
REQ-003 SHALL have parameter PRESCALE, default 1000, the clk cycles per timestamp tick (>=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port capture, input, 32 bits: the per-button capture word from the button capture stage; bits >= NUM_BUTTONS are ignored.
REQ-007 SHALL have port enable_mask, input, NUM_BUTTONS bits: per-button event enable.
REQ-008 SHALL have port clear, input, 1 bit: synchronous flush of queue, overflow and timestamp.
REQ-009 SHALL have port rd_en, input, 1 bit: pop the head entry.
REQ-010 SHALL have port rd_data, output, 32 bits: the head entry, show-ahead.
REQ-011 SHALL have port empty, output, 1 bit: queue holds zero entries.
REQ-012 SHALL have port full, output, 1 bit: queue holds DEPTH entries.
REQ-013 SHALL have port count, output, 9 bits: the number of entries held.
REQ-014 SHALL have port overflow, output, 1 bit: sticky, set when an event was dropped.
REQ-015 SHALL have port irq, output, 1 bit: registered, equal to (!empty | overflow).

Function
REQ-016 SHALL register capture[NUM_BUTTONS-1:0] each cycle as prev; hit = capture & ~prev & enable_mask (rising edges only).
REQ-017 SHALL push one entry in cycle N when hit != 0; multiple buttons rising in the same cycle share one entry.
REQ-018 Entry format SHALL be: [31:16] timestamp at cycle N; [15:0] hit, zero-extended.
REQ-019 SHALL drive the timestamp from a prescaler counting 0..PRESCALE-1; the 16-bit timestamp increments when the prescaler wraps, and the timestamp wraps FFFF->0000 silently.
REQ-020 SHALL make a pushed entry visible on rd_data/empty/count in cycle N+1 (1-cycle latency).
REQ-021 A pop SHALL occur on rd_en && !empty; rd_en while empty is ignored without error.
REQ-022 rd_data SHALL always show the oldest entry; its value is 0 when empty.
REQ-023 On push && pop in the same cycle (not empty), both SHALL occur and count is unchanged, including when full.
REQ-024 On push while full without pop, the entry SHALL be dropped, queue contents unchanged, and overflow set to 1.
REQ-025 On push while empty with rd_en, the push SHALL occur and the pop is ignored.
REQ-026 overflow SHALL clear only on clear or reset.
REQ-027 clear SHALL have priority over push and pop: pointers, count, overflow, prescaler and timestamp go to 0 next cycle, and prev is still updated.
REQ-028 full and empty SHALL derive from count; count SHALL never exceed DEPTH.
REQ-029 irq SHALL lag its inputs by one cycle.

Reset
REQ-030 While rst=0, SHALL asynchronously force: pointers, count, prescaler, timestamp, overflow, irq, prev to 0; empty=1, full=0, rd_data=0.
REQ-031 On rst deassertion mid-operation, all prior entries SHALL be lost, and a capture bit already high at release is not an event until it falls and rises again.
REQ-032 Memory array contents SHALL need no reset; outputs must not expose them while empty.

Structure
REQ-033 A shared package button_pkg SHALL hold the entry field constants (TS_MSB=31, TS_LSB=16, MASK_MSB=15, MASK_LSB=0) and the entry width of 32.
REQ-034 One sub-module event_fifo SHALL be used: a parameterised synchronous show-ahead FIFO with push, pop, clear, count, full, empty and async active-low rst.
REQ-035 Edge detection, prescaler/timestamp, overflow and irq SHALL be implemented in button_event_queue.

Verification
REQ-036 Reset, then capture[2] rises once with PRESCALE=1 and 5 cycles elapsed -> next cycle empty=0, count=1, rd_data=0x0005_0004, irq=1 one cycle later.
REQ-037 capture[0] and capture[3] rise in the same cycle -> exactly one entry with mask field 0x0009; holding both high adds no further entries.
REQ-038 Fill 16 entries, then one more edge -> count=16, full=1, overflow=1, head entry unchanged; then push and pop in the same cycle -> count stays 16, overflow stays 1.
REQ-039 enable_mask=0xFE and capture[0] toggles -> no entries; rd_en on empty -> count stays 0, rd_data=0.
REQ-040 With 3 entries queued and overflow set, clear=1 while an edge arrives -> next cycle count=0, overflow=0, timestamp=0, irq=0 the following cycle.
REQ-041 Assert rst mid-stream with capture[1] held high -> outputs reset immediately; after release, no entry until capture[1] falls and rises again.
